// File: rtl/redmule_mx_encoder_if.sv
// redmule_mx_encoder_if: FP16 beat input plus MX value/exponent output handshakes
interface redmule_mx_encoder_if #(
  parameter int DATA_W = 256,
  parameter int BITW = 16,
  parameter int NUM_LANES = 8
);
  logic fp16_valid_i;
  logic fp16_ready_o;
  logic [NUM_LANES*BITW-1:0] fp16_data_i;
  logic mx_val_valid_o;
  logic mx_val_ready_i;
  logic [DATA_W-1:0] mx_val_data_o;
  logic mx_exp_valid_o;
  logic mx_exp_ready_i;
  logic [7:0] mx_exp_data_o;
  modport slave (
    input fp16_valid_i, fp16_data_i, mx_val_ready_i, mx_exp_ready_i,
    output fp16_ready_o, mx_val_valid_o, mx_val_data_o, mx_exp_valid_o, mx_exp_data_o
  );
  modport master (
    output fp16_valid_i, fp16_data_i, mx_val_ready_i, mx_exp_ready_i,
    input fp16_ready_o, mx_val_valid_o, mx_val_data_o, mx_exp_valid_o, mx_exp_data_o
  );
endinterface

// File: rtl/redmule_mx_encoder.sv
// redmule_mx_encoder: FP16 block to MXFP8 E4M3 values plus E8M0 shared exponent
module redmule_mx_encoder #(
  parameter int DATA_W = 256,
  parameter int BITW = 16,
  parameter int NUM_LANES = 8
) (
  input logic clk_i,
  input logic rst_i,
  redmule_mx_encoder_if.slave bus
);
  localparam int NUM_ELEMS = DATA_W / 8;
  localparam int NUM_BEATS = NUM_ELEMS / NUM_LANES;
  localparam int CW = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
  if (NUM_ELEMS % NUM_LANES != 0) begin : g_chk
    $error("NUM_ELEMS must be a multiple of NUM_LANES");
  end
  typedef enum logic [1:0] {S_COLLECT, S_MAX, S_CONV, S_OUT} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_buf [NUM_ELEMS];
  logic [5:0] r_kmax, w_kmax;
  logic r_special, w_special, w_nz;
  logic r_val_v, r_exp_v;
  logic [DATA_W-1:0] r_val;
  logic [7:0] r_exp;
  logic w_acc, w_last, w_val_done, w_exp_done;
  // k = effective exponent + 24, so FP16 subnormals map to 0..9 and normals to 10..39
  function automatic logic [5:0] k_of(input logic [15:0] x);
    k_of = 6'(x[14:10]) + 6'd9;
    if (x[14:10] == 5'd0)
      for (int i = 0; i < 10; i++) if (x[i]) k_of = 6'(i);
  endfunction
  // v holds the scaled magnitude in units of the E4M3 subnormal step with 12 fraction bits
  function automatic logic [7:0] enc(input logic [15:0] x, input logic [5:0] kmax);
    logic [29:0] v;
    logic [4:0] q;
    logic g, st;
    int sh, pos, s, c;
    sh = int'(x[14:10] == 5'd0 ? 5'd1 : x[14:10]) - int'(kmax) + 28;
    v = sh < 0 ? '0 : 30'({x[14:10] != 5'd0, x[9:0]}) << sh;
    pos = 15;
    for (int i = 16; i < 30; i++) if (v[i]) pos = i;
    s = pos - 3;
    q = 5'(v >> s);
    g = v[s-1];
    st = |(v & ((30'd1 << (s - 1)) - 30'd1));
    c = (pos - 15) * 8 + int'(q + 5'(g & (st | q[0])));
    enc = {x[15], c > 126 ? 7'd126 : 7'(c)};
  endfunction
  assign w_acc = bus.fp16_valid_i && r_state == S_COLLECT;
  assign w_last = r_cnt == CW'(NUM_BEATS - 1);
  assign w_val_done = !r_val_v || bus.mx_val_ready_i;
  assign w_exp_done = !r_exp_v || bus.mx_exp_ready_i;
  assign bus.fp16_ready_o = r_state == S_COLLECT;
  assign bus.mx_val_valid_o = r_val_v;
  assign bus.mx_exp_valid_o = r_exp_v;
  assign bus.mx_val_data_o = r_val;
  assign bus.mx_exp_data_o = r_exp;
  always_comb begin
    w_kmax = '0;
    w_nz = 1'b0;
    w_special = 1'b0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (r_buf[i][14:0] != 15'd0 && k_of(r_buf[i]) > w_kmax) w_kmax = k_of(r_buf[i]);
      w_nz = w_nz | (r_buf[i][14:0] != 15'd0);
      w_special = w_special | (&r_buf[i][14:10]);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_COLLECT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: w_next = w_acc && w_last ? S_MAX : S_COLLECT;
      S_MAX: w_next = S_CONV;
      S_CONV: w_next = S_OUT;
      default: w_next = w_val_done && w_exp_done ? S_COLLECT : S_OUT;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (w_acc)
      for (int l = 0; l < NUM_LANES; l++)
        r_buf[NUM_LANES*int'(r_cnt) + l] <= bus.fp16_data_i[BITW*l +: 16];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_val_v <= 1'b0;
      r_exp_v <= 1'b0;
      r_val <= '0;
      r_exp <= '0;
      r_kmax <= '0;
      r_special <= 1'b0;
    end else begin
      if (w_acc) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (r_state == S_MAX) begin
        r_kmax <= w_kmax;
        r_special <= w_special;
        r_exp <= w_special ? 8'hFF : w_nz ? 8'(w_kmax) + 8'd95 : 8'h00;
      end
      if (r_state == S_CONV) begin
        for (int i = 0; i < NUM_ELEMS; i++)
          r_val[8*i +: 8] <= r_special ? 8'h7F : enc(r_buf[i], r_kmax);
        r_val_v <= 1'b1;
        r_exp_v <= 1'b1;
      end
      if (r_val_v && bus.mx_val_ready_i) r_val_v <= 1'b0;
      if (r_exp_v && bus.mx_exp_ready_i) r_exp_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_redmule_mx_encoder.sv
// tb_redmule_mx_encoder: random and directed blocks checked against a real-valued MX reference
module tb_redmule_mx_encoder;
  localparam int DATA_W = 256, BITW = 16, NUM_LANES = 8;
  localparam int NE = DATA_W / 8, NB = NE / NUM_LANES;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0, errors = 0;
  redmule_mx_encoder_if #(.DATA_W(DATA_W), .BITW(BITW), .NUM_LANES(NUM_LANES)) bus ();
  redmule_mx_encoder #(.DATA_W(DATA_W), .BITW(BITW), .NUM_LANES(NUM_LANES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  function automatic real p2(int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction
  function automatic real fp16_mag(logic [15:0] x);
    if (x[14:10] == 5'd0) return real'(int'(x[9:0])) * p2(-24);
    return real'(1024 + int'(x[9:0])) * p2(int'(x[14:10]) - 25);
  endfunction
  function automatic real e4m3_mag(int c);
    if (c / 8 == 0) return real'(c % 8) * p2(-9);
    return real'(8 + c % 8) * p2(c / 8 - 10);
  endfunction
  // Reference: find e_max from real magnitudes, then pick the nearest E4M3 code (ties to even code)
  task automatic model(input logic [15:0] el[NE], output logic [7:0] exp_r, output logic [DATA_W-1:0] val_r);
    bit sp = 0, nz = 0;
    int emax = -100, le, best;
    real a, d, bd;
    for (int i = 0; i < NE; i++) begin
      if (el[i][14:10] == 5'h1F) sp = 1;
      else if (fp16_mag(el[i]) > 0.0) begin
        nz = 1;
        for (int e = -24; e <= 15; e++) if (fp16_mag(el[i]) >= p2(e)) le = e;
        if (le > emax) emax = le;
      end
    end
    if (!nz) emax = 0;
    exp_r = sp ? 8'hFF : nz ? 8'(emax + 119) : 8'h00;
    for (int i = 0; i < NE; i++) begin
      a = fp16_mag(el[i]) / p2(emax - 8);
      best = 0;
      bd = a;
      for (int c = 1; c < 127; c++) begin
        d = a > e4m3_mag(c) ? a - e4m3_mag(c) : e4m3_mag(c) - a;
        if (d < bd || (d == bd && c % 2 == 0)) begin
          best = c;
          bd = d;
        end
      end
      val_r[8*i +: 8] = sp ? 8'h7F : {el[i][15], 7'(best)};
    end
  endtask
  function automatic logic [15:0] gen(int base);
    int r = int'($urandom_range(0, 15));
    int e;
    logic s = 1'($urandom);
    logic [9:0] m = 10'($urandom);
    if (r > 10) m = m & 10'h3F0;
    if (r == 0) return {s, 15'd0};
    if (r == 1 || base == 0) return {s, 5'd0, m};
    e = (r == 2) ? int'($urandom_range(1, 30)) : base - int'($urandom_range(0, 10));
    return {s, 5'(e < 1 ? 1 : e), m};
  endfunction
  task automatic send_beat(input logic [NUM_LANES*BITW-1:0] d, input int max_gap);
    int w = 0;
    repeat (int'($urandom_range(0, max_gap))) cyc();
    bus.fp16_valid_i = 1'b1;
    bus.fp16_data_i = d;
    while (!bus.fp16_ready_o && w < 50) begin
      cyc();
      w++;
    end
    checks++;
    if (w == 50) begin
      errors++;
      $display("FAIL beat_ready: ready=%0b required 1 within 50 cycles", bus.fp16_ready_o);
    end
    cyc();
    bus.fp16_valid_i = 1'b0;
  endtask
  // Sends a block, checks latency and data; with hs=1 also completes both handshakes
  task automatic run_block(input logic [15:0] el[NE], input int max_gap, input logic [7:0] exp_e,
                           input logic [DATA_W-1:0] val_e, input bit hs, input string name);
    logic [NUM_LANES*BITW-1:0] d;
    for (int b = 0; b < NB; b++) begin
      for (int l = 0; l < NUM_LANES; l++) d[BITW*l +: BITW] = el[b*NUM_LANES + l];
      send_beat(d, max_gap);
    end
    checks++;
    if (bus.fp16_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_last: got %0b required 0", name, bus.fp16_ready_o);
    end
    cyc();
    checks++;
    if ({bus.mx_val_valid_o, bus.mx_exp_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL %s early_valid: got %b required 00", name, {bus.mx_val_valid_o, bus.mx_exp_valid_o});
    end
    cyc();
    checks++;
    if ({bus.mx_val_valid_o, bus.mx_exp_valid_o} !== 2'b11) begin
      errors++;
      $display("FAIL %s valid_rise: got %b required 11", name, {bus.mx_val_valid_o, bus.mx_exp_valid_o});
    end
    checks++;
    if (bus.mx_exp_data_o !== exp_e) begin
      errors++;
      $display("FAIL %s exp: got %h required %h", name, bus.mx_exp_data_o, exp_e);
    end
    checks++;
    if (bus.mx_val_data_o !== val_e) begin
      errors++;
      $display("FAIL %s val: got %h required %h", name, bus.mx_val_data_o, val_e);
    end
    if (hs) begin
      cyc();
      checks++;
      if ({bus.mx_val_valid_o, bus.mx_exp_valid_o, bus.fp16_ready_o} !== 3'b001) begin
        errors++;
        $display("FAIL %s after_hs: got valids/ready %b required 001", name,
                 {bus.mx_val_valid_o, bus.mx_exp_valid_o, bus.fp16_ready_o});
      end
    end
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) cyc();
    checks++;
    if ({bus.fp16_ready_o, bus.mx_val_valid_o, bus.mx_exp_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 100", {bus.fp16_ready_o, bus.mx_val_valid_o, bus.mx_exp_valid_o});
    end
    checks++;
    if (bus.mx_val_data_o !== '0 || bus.mx_exp_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got val %h exp %h required 0", bus.mx_val_data_o, bus.mx_exp_data_o);
    end
    rst_i = 1'b0;
    cyc();
  endtask
  task automatic test_directed();
    logic [15:0] el[NE];
    logic [DATA_W-1:0] v;
    for (int i = 0; i < NE; i++) begin
      el[i] = 16'h3C00;
      v[8*i +: 8] = 8'h78;
    end
    run_block(el, 0, 8'h77, v, 1, "ones");
    el[0] = 16'h4000;
    for (int i = 1; i < NE; i++) v[8*i +: 8] = 8'h70;
    run_block(el, 1, 8'h78, v, 1, "two");
    el[0] = 16'h3C00;
    el[1] = 16'h3FFF;
    el[2] = 16'hBFFF;
    el[3] = 16'h0400;
    el[4] = 16'h0100;
    el[5] = 16'h8000;
    for (int i = 0; i < NE; i++) v[8*i +: 8] = 8'h78;
    v[15:8] = 8'h7E;
    v[23:16] = 8'hFE;
    v[31:24] = 8'h08;
    v[39:32] = 8'h02;
    v[47:40] = 8'h80;
    run_block(el, 0, 8'h77, v, 1, "edges");
    for (int i = 0; i < NE; i++) el[i] = 16'h0000;
    run_block(el, 0, 8'h00, '0, 1, "zeros");
    for (int i = 0; i < NE; i++) begin
      el[i] = gen(15);
      v[8*i +: 8] = 8'h7F;
    end
    el[$urandom_range(0, NE - 1)] = 16'h7C00;
    run_block(el, 2, 8'hFF, v, 1, "inf");
  endtask
  task automatic test_random();
    logic [15:0] el[NE];
    logic [7:0] e;
    logic [DATA_W-1:0] v;
    int base;
    for (int n = 0; n < 24; n++) begin
      base = (n % 5 == 4) ? 0 : int'($urandom_range(1, 30));
      for (int i = 0; i < NE; i++) el[i] = gen(base);
      model(el, e, v);
      run_block(el, n % 3, e, v, 1, $sformatf("rand%0d", n));
    end
  endtask
  task automatic test_backpressure();
    logic [15:0] el[NE];
    logic [7:0] e;
    logic [DATA_W-1:0] v;
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < NE; i++) el[i] = gen(12);
      model(el, e, v);
      bus.mx_exp_ready_i = (mode == 0);
      bus.mx_val_ready_i = (mode == 1);
      run_block(el, 0, e, v, 0, $sformatf("bp%0d", mode));
      for (int c = 0; c < 5; c++) begin
        cyc();
        checks++;
        if ({bus.mx_val_valid_o, bus.mx_exp_valid_o, bus.fp16_ready_o} !== (mode == 0 ? 3'b100 : 3'b010)
            || bus.mx_val_data_o !== v || bus.mx_exp_data_o !== e) begin
          errors++;
          $display("FAIL bp%0d hold%0d: got valids/ready %b val %h exp %h required val %h exp %h", mode, c,
                   {bus.mx_val_valid_o, bus.mx_exp_valid_o, bus.fp16_ready_o}, bus.mx_val_data_o,
                   bus.mx_exp_data_o, v, e);
        end
      end
      bus.mx_val_ready_i = 1'b1;
      bus.mx_exp_ready_i = 1'b1;
      cyc();
      checks++;
      if ({bus.mx_val_valid_o, bus.mx_exp_valid_o, bus.fp16_ready_o} !== 3'b001) begin
        errors++;
        $display("FAIL bp%0d release: got %b required 001", mode,
                 {bus.mx_val_valid_o, bus.mx_exp_valid_o, bus.fp16_ready_o});
      end
    end
  endtask
  task automatic test_gap_reset();
    logic [15:0] el[NE];
    logic [7:0] e;
    logic [DATA_W-1:0] v;
    logic [NUM_LANES*BITW-1:0] d;
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < NUM_LANES; l++) d[BITW*l +: BITW] = 16'h7C00;
      send_beat(d, 3);
    end
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    checks++;
    if ({bus.fp16_ready_o, bus.mx_val_valid_o, bus.mx_exp_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL midreset: got %b required 100", {bus.fp16_ready_o, bus.mx_val_valid_o, bus.mx_exp_valid_o});
    end
    for (int i = 0; i < NE; i++) el[i] = gen(20);
    model(el, e, v);
    run_block(el, 3, e, v, 1, "after_reset");
  endtask
  initial begin
    bus.fp16_valid_i = 1'b0;
    bus.fp16_data_i = '0;
    bus.mx_val_ready_i = 1'b1;
    bus.mx_exp_ready_i = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_gap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
